fifo_write_arbiter_rr: RTL
==========================

// Module: fifo_write_arbiter_rr
// PURPOSE
//  Round-robin write arbiter sharing one fifo_fwft write port among N requesters (decoder stage outputs).
//  Grants at most one requester per cycle and supports bounded bursts.
//  Writes {source id, data} into the FIFO.
//  Sits between the per-unit message producers and the shared message FIFO.
// PARAMETERS
//  N          4   number of requesters, >=2, need not be a power of 2
//  WIDTH      8   payload width in bits
//  MAX_BURST  4   max consecutive transfers held by one owner, >=1 (1 = pure round-robin)
//  IDW        $clog2(N)  source id width (derived localparam, not overridable)
// PORTS
//  clk        in   1            clock
//  srst       in   1            synchronous reset, active-high
//  arb_en     in   1            0 = grant nobody; state frozen
//  req_valid  in   N            requester i has a word
//  req_data   in   N*WIDTH      payload, slice i = [i*WIDTH +: WIDTH]
//  req_ready  out  N            one-hot or zero; word i accepted when req_valid[i] & req_ready[i]
//  fifo_full  in   1            from fifo_fwft.full
//  fifo_wr_en out  1            to fifo_fwft.wr_en
//  fifo_din   out  IDW+WIDTH    {id, data} to fifo_fwft.din; id in MSBs
//  busy       out  1            state == BURST
// BEHAVIOUR
//  Reset: srst=1 forces state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
//   req_ready=0, fifo_wr_en=0 and busy=0 combinationally while srst is high.
//  Grant path is combinational from req_valid/fifo_full/state; zero-cycle latency.
//   A word is in the FIFO on the clk edge where fifo_wr_en=1.
//  Winner selection:
//   - BURST with req_valid[owner]=1 and burst_cnt<MAX_BURST: winner = owner.
//   - Otherwise: first valid index scanning rr_ptr, rr_ptr+1, ... modulo N (explicit wrap, no power-of-2 masking).
//  Transfer: fire = arb_en & !fifo_full & any winner.
//   req_ready[winner]=fire; fifo_wr_en=fire; fifo_din={winner[IDW-1:0], req_data[winner]}.
//  fifo_din is don't-care when fifo_wr_en=0; drive it from the winner anyway.
//  States: IDLE, BURST (encoding in package).
//   IDLE -> BURST  on fire with MAX_BURST>1: owner<=winner, burst_cnt<=1.
//   IDLE stays     on fire with MAX_BURST==1: rr_ptr<=winner+1 (mod N).
//   BURST, fire, winner==owner, burst_cnt+1<MAX_BURST: burst_cnt<=burst_cnt+1.
//   BURST, fire, winner==owner, burst_cnt+1==MAX_BURST: rr_ptr<=owner+1, ->IDLE, burst_cnt<=0.
//   BURST, req_valid[owner]=0: release; same cycle, scan from owner+1.
//    If fire: new owner<=winner, burst_cnt<=1, stay BURST.
//    If no fire: rr_ptr<=owner+1, ->IDLE.
//  fifo_full=1 or arb_en=0: no fire; state, owner, burst_cnt and rr_ptr all hold.
//   A burst survives a full stall.
//  Requesters must hold req_valid/req_data until accepted; the arbiter never drops a granted word.
//  No req_valid set: no fire, state IDLE (or release per above).
//  srst mid-burst: next cycle IDLE, rr_ptr=0; no partial write.
//   Any word presented in the srst cycle is not written.
//  Counter widths: burst_cnt is $clog2(MAX_BURST+1) bits; rr_ptr and owner are IDW bits, always <N.
// STRUCTURE
//  Package arb_pkg: state localparams (ST_IDLE=1'b0, ST_BURST=1'b1) and a helper function for IDW with a floor of 1.
//  Sub-module rr_priority_pick #(N): combinational rotate-priority encoder.
//   Inputs (req, start_idx); outputs (found, idx).
//   Instantiated once for the scan; owner-hold logic lives in the top.
//  Top: FSM, rr_ptr/owner/burst_cnt regs, output mux.
// TESTING (N=4, WIDTH=8, MAX_BURST=4, with a real fifo_fwft DEPTH=16 downstream)
//  1. After srst, all req_valid=1 with data 8'hA0+i, never full -> FIFO receives ids 0,0,0,0,1,1,1,1,2,...
//     Each burst is 4 long; busy high during bursts.
//  2. Only req 2 valid, with 10 words -> bursts of 4,4,2.
//     No idle cycle between bursts, because the rr scan from 3 wraps back to 2.
//  3. Owner 1 drops valid after 2 words while req 3 is valid -> the same cycle grants 3.
//     FIFO shows 1,1,3,...; no bubble.
//  4. FIFO fills (16th push -> full=1) mid-burst -> req_ready=0 and wr_en=0 while full.
//     After one pop, the same owner resumes with burst_cnt unchanged; no word lost or duplicated (scoreboard).
//  5. arb_en=0 for 5 cycles with all valid -> no writes, state frozen.
//     Re-enable continues exactly where it left off.
//  6. srst asserted mid-burst (owner 2, burst_cnt=2) -> outputs 0 in the reset cycle.
//     Afterwards rr starts at id 0.

Source files
------------

// File: rtl/fifo_write_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter_rr_pkg
//  Purpose  : Shared FSM encoding and width helper for the FIFO write arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_write_arbiter_rr_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Source id width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter_rr_if
//  Purpose  : Requester bundle plus FIFO write port seen by the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_write_arbiter_rr_if
    import fifo_write_arbiter_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = id_width(N)
);

    logic                 arb_en;
    logic [N-1:0]         req_valid;
    logic [N*WIDTH-1:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [IDW+WIDTH-1:0] fifo_din;
    logic                 busy;

    modport master (
        output arb_en,
        output req_valid,
        output req_data,
        input  req_ready,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_din,
        input  busy
    );

    modport slave (
        input  arb_en,
        input  req_valid,
        input  req_data,
        output req_ready,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_din,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_pick
//  Purpose  : Rotating-priority encoder: first set request at or after start.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  wire logic [N-1:0]   i_req,
    input  wire logic [IDW-1:0] i_start_idx,
    output logic                o_found,
    output logic [IDW-1:0]      o_idx
);

    // Walk from the far end back to the start so the closest hit is written last.
    always_comb begin : p_scan
        int pos;
        o_found = 1'b0;
        o_idx   = '0;
        pos     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(i_start_idx) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (i_req[pos[IDW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = pos[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter_rr
//  Purpose  : Round-robin, burst-capable arbiter feeding one shared FWFT FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter_rr
    import fifo_write_arbiter_rr_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic               clk,
    input  wire logic               srst,
    fifo_write_arbiter_rr_if.slave  bus
);

    localparam int              IDW         = id_width(N);
    localparam int              CW          = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0]  c_LAST      = IDW'(N - 1);
    localparam logic [CW-1:0]   c_MAX_BURST = CW'(MAX_BURST);
    localparam logic [CW-1:0]   c_ONE       = CW'(1);

    logic [0:0]     r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_owner;
    logic [CW-1:0]  r_burst_cnt;

    logic [0:0]     w_state_nxt;
    logic [IDW-1:0] w_rr_ptr_nxt;
    logic [IDW-1:0] w_owner_nxt;
    logic [CW-1:0]  w_burst_cnt_nxt;

    logic           w_in_burst;
    logic           w_owner_valid;
    logic           w_hold;
    logic           w_release;
    logic [IDW-1:0] w_scan_start;
    logic           w_scan_found;
    logic [IDW-1:0] w_scan_idx;
    logic [IDW-1:0] w_winner;
    logic           w_any;
    logic           w_can_xfer;
    logic           w_fire;
    logic [CW-1:0]  w_cnt_inc;
    logic [WIDTH-1:0] w_win_data;

    function automatic logic [IDW-1:0] f_wrap_inc(input logic [IDW-1:0] idx);
        return (idx == c_LAST) ? '0 : idx + 1'b1;
    endfunction

    // Winner selection: a live burst keeps its owner, otherwise rotate.
    assign w_in_burst    = (r_state == ST_BURST);
    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_hold        = w_in_burst & w_owner_valid & (r_burst_cnt < c_MAX_BURST);
    assign w_release     = w_in_burst & ~w_owner_valid;
    assign w_scan_start  = w_release ? f_wrap_inc(r_owner) : r_rr_ptr;

    rr_priority_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req       (bus.req_valid),
        .i_start_idx (w_scan_start),
        .o_found     (w_scan_found),
        .o_idx       (w_scan_idx)
    );

    assign w_winner   = w_hold ? r_owner : w_scan_idx;
    assign w_any      = w_hold | w_scan_found;
    assign w_can_xfer = ~srst & bus.arb_en & ~bus.fifo_full;
    assign w_fire     = w_can_xfer & w_any;
    assign w_cnt_inc  = r_burst_cnt + 1'b1;
    assign w_win_data = bus.req_data[int'(w_winner) * WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Stalls (full FIFO, arbiter disabled) fall through with everything held.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    if (MAX_BURST > 1) begin
                        w_state_nxt     = ST_BURST;
                        w_owner_nxt     = w_winner;
                        w_burst_cnt_nxt = c_ONE;
                    end else begin
                        w_rr_ptr_nxt    = f_wrap_inc(w_winner);
                    end
                end
            end
            ST_BURST: begin
                if (w_hold) begin
                    if (w_fire) begin
                        if (w_cnt_inc < c_MAX_BURST) begin
                            w_burst_cnt_nxt = w_cnt_inc;
                        end else begin
                            w_state_nxt     = ST_IDLE;
                            w_rr_ptr_nxt    = f_wrap_inc(r_owner);
                            w_burst_cnt_nxt = '0;
                        end
                    end
                end else if (w_fire) begin
                    // Owner dropped out; the next requester inherits a fresh burst.
                    w_owner_nxt     = w_winner;
                    w_burst_cnt_nxt = c_ONE;
                end else if (w_can_xfer) begin
                    w_state_nxt     = ST_IDLE;
                    w_rr_ptr_nxt    = f_wrap_inc(r_owner);
                    w_burst_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_ready           = '0;
        bus.req_ready[w_winner] = w_fire;
        bus.fifo_wr_en          = w_fire;
        bus.fifo_din            = {w_winner, w_win_data};
        bus.busy                = w_in_burst & ~srst;
    end

endmodule
`default_nettype wire
